digit_ring_rotator: RTL and testbench
=====================================

DIGIT_RING_ROTATOR -- requirements
Module: digit_ring_rotator

Interface
REQ-001 Parameter NUM_DIGITS, default 10, ring length in digits; SHALL be >= 2.
REQ-002 Parameter WIN, default 4, displayed window width in digits; SHALL be 1..NUM_DIGITS.
REQ-003 Parameter DIGIT_W, default 4, bits per digit.
REQ-004 Parameter TICK_DIV, default 50_000_000, clocks per auto-rotate step; SHALL be >= 1.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 key  in  1  manual step request, level; stepping uses the rising edge only.
REQ-008 key_enable  in  1  gates manual stepping.
REQ-009 up  in  1  direction: 1 = rotate left (MSB digit wraps to LSB), 0 = rotate right.
REQ-010 rotate  in  1  auto-rotate mode select.
REQ-011 load  in  1  one-cycle load strobe.
REQ-012 load_data  in  NUM_DIGITS*DIGIT_W  ring image, digit 0 in MSBs.
REQ-013 d_out  out  WIN*DIGIT_W  ring digits 0..WIN-1, digit 0 in MSBs.
REQ-014 pos  out  $clog2(NUM_DIGITS)  current rotation offset, 0..NUM_DIGITS-1.
REQ-015 step_pulse  out  1  high for exactly the cycle after each ring step.

Function
REQ-016 Ring SHALL be a NUM_DIGITS*DIGIT_W register; d_out and pos SHALL be driven directly from registers, with no combinational path from inputs.
REQ-017 Left step: ring <= {ring[digits 1..N-1], ring[digit 0]}; right step: ring <= {ring[digit N-1], ring[digits 0..N-2]}.
REQ-018 Key edge: key_q registered each cycle; key_rise = key & ~key_q.
REQ-019 Tick counter SHALL count 0..TICK_DIV-1 while rotate=1, assert tick when count==TICK_DIV-1, then wrap to 0; while rotate=0 it SHALL hold 0.
REQ-020 Step condition: (rotate & tick) | (~rotate & key_enable & key_rise); key is ignored while rotate=1.
REQ-021 Priority per cycle: reset > load > step.
REQ-022 On load: ring <= load_data, pos <= 0, tick counter <= 0, no step that cycle, step_pulse stays 0.
REQ-023 pos SHALL increment mod NUM_DIGITS on a left step and decrement mod NUM_DIGITS on a right step; N-1+1 wraps to 0 and 0-1 wraps to N-1.
REQ-024 Latency: a step qualified in cycle k SHALL update ring/d_out/pos at the edge ending cycle k; step_pulse SHALL be high in cycle k+1.
REQ-025 rotate falling mid-count SHALL abandon the partial count; re-entering rotate SHALL take the full TICK_DIV clocks before the first step.
REQ-026 A key held high SHALL produce exactly one step.

Reset
REQ-027 On reset: digit i <= i mod 2^DIGIT_W, pos <= 0, tick counter <= 0, key_q <= 1 (a key held through reset SHALL NOT step), synchroniser flops <= 1, step_pulse <= 0.
REQ-028 Reset asserted mid-count or during a held key SHALL take effect at the next edge and override load and step.

Configuration
REQ-029 With DIGIT_RING_KEY_SYNC_EN defined, key SHALL pass through a 2-flop synchroniser before edge detection, adding exactly 2 cycles to manual-step latency.
REQ-030 Without DIGIT_RING_KEY_SYNC_EN, key SHALL feed edge detection directly; all other behaviour SHALL be identical.

Structure
REQ-031 Package digit_ring_pkg SHALL hold the default parameter constants and the reset-pattern function (digit index -> value).
REQ-032 Sub-module ring_tick_gen SHALL implement the TICK_DIV counter with a clear input and a tick output; ring, pos and key logic SHALL stay in the top module.

Verification
REQ-033 Reset, defaults -> d_out=0x0123, pos=0, step_pulse=0.
REQ-034 rotate=0, key_enable=1, up=1, one key rising edge held 5 cycles -> d_out=0x1234, pos=1, exactly one step_pulse; up=0 repeated twice from reset -> d_out=0x8901, pos=8.
REQ-035 rotate=1, TICK_DIV=3, up=1, 9 clocks -> 3 steps, d_out=0x3456, pos=3; drop rotate after 2 clocks, re-raise -> first step 3 clocks later.
REQ-036 Wrap: 10 left steps from reset -> d_out=0x0123, pos=0; key_enable=0 with key toggling -> no change.
REQ-037 load with load_data=0x9876543210 in the same cycle as key_rise -> d_out=0x9876, pos=0, no step_pulse; reset in the same cycle as load -> reset pattern.
REQ-038 Run REQ-034 with DIGIT_RING_KEY_SYNC_EN defined -> step_pulse 2 cycles later than without it; values unchanged.

Source files
------------

// File: rtl/digit_ring_pkg.sv
// Shared defaults and the reset-pattern helper for the digit ring rotator.
// The optional key synchroniser is enabled with the DIGIT_RING_KEY_SYNC_EN macro.
package digit_ring_pkg;

  localparam int DEF_NUM_DIGITS = 10;
  localparam int DEF_WIN        = 4;
  localparam int DEF_DIGIT_W    = 4;
  localparam int DEF_TICK_DIV   = 50_000_000;

  // Reset value of digit idx: its index, truncated to the digit width.
  function automatic int resetDigit(input int idx, input int width);
    if (width >= 31) return idx;
    return idx % (1 << width);
  endfunction

endpackage

// File: rtl/ring_tick_gen.sv
// Auto-rotate tick generator: counts 0..TICK_DIV-1 while enabled, ticks on the last count.
// Clear or disable drops any partial count so a fresh run always takes TICK_DIV clocks.
module ring_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_atMax;

  assign w_atMax = (r_count == CNT_MAX);
  assign o_tick  = i_enable & w_atMax;

  always_ff @(posedge clk) begin
    if (reset || i_clear || !i_enable) begin
      r_count <= '0;
    end else if (w_atMax) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/digit_ring_rotator.sv
// Digit ring rotator: a ring of digits stepped by key edges or an auto-rotate tick.
// Define DIGIT_RING_KEY_SYNC_EN to pass key through a 2-flop synchroniser first.
module digit_ring_rotator
  import digit_ring_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int WIN        = DEF_WIN,
  parameter int DIGIT_W    = DEF_DIGIT_W,
  parameter int TICK_DIV   = DEF_TICK_DIV
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            key,
  input  logic                            key_enable,
  input  logic                            up,
  input  logic                            rotate,
  input  logic                            load,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]   load_data,
  output logic [WIN*DIGIT_W-1:0]          d_out,
  output logic [$clog2(NUM_DIGITS)-1:0]   pos,
  output logic                            step_pulse
);

  localparam int RING_W = NUM_DIGITS * DIGIT_W;
  localparam int POS_W  = $clog2(NUM_DIGITS);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(NUM_DIGITS - 1);

  logic [RING_W-1:0] r_ring;
  logic [POS_W-1:0]  r_pos;
  logic              r_keyQ;
  logic              r_stepPulse;
  logic [RING_W-1:0] w_resetImage;
  logic              w_keyIn;
  logic              w_keyRise;
  logic              w_tick;
  logic              w_step;

  always_comb begin
    w_resetImage = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_resetImage[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W] = DIGIT_W'(resetDigit(i, DIGIT_W));
    end
  end

`ifdef DIGIT_RING_KEY_SYNC_EN
  logic r_keySync1;
  logic r_keySync2;

  // Flops preset high so a key held through reset never looks like a fresh press.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_keySync1 <= 1'b1;
      r_keySync2 <= 1'b1;
    end else begin
      r_keySync1 <= key;
      r_keySync2 <= r_keySync1;
    end
  end

  assign w_keyIn = r_keySync2;
`else
  assign w_keyIn = key;
`endif

  assign w_keyRise = w_keyIn & ~r_keyQ;
  assign w_step    = (rotate & w_tick) | (~rotate & key_enable & w_keyRise);

  ring_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tickGen (
    .clk      (clk),
    .reset    (reset),
    .i_enable (rotate),
    .i_clear  (load),
    .o_tick   (w_tick)
  );

  // Digit 0 sits in the MSBs, so a left step moves the top digit to the bottom.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ring      <= w_resetImage;
      r_pos       <= '0;
      r_keyQ      <= 1'b1;
      r_stepPulse <= 1'b0;
    end else begin
      r_keyQ      <= w_keyIn;
      r_stepPulse <= 1'b0;
      if (load) begin
        r_ring <= load_data;
        r_pos  <= '0;
      end else if (w_step) begin
        r_stepPulse <= 1'b1;
        if (up) begin
          r_ring <= {r_ring[RING_W-DIGIT_W-1:0], r_ring[RING_W-1 -: DIGIT_W]};
          r_pos  <= (r_pos == POS_MAX) ? '0 : r_pos + 1'b1;
        end else begin
          r_ring <= {r_ring[DIGIT_W-1:0], r_ring[RING_W-1:DIGIT_W]};
          r_pos  <= (r_pos == '0) ? POS_MAX : r_pos - 1'b1;
        end
      end
    end
  end

  assign d_out      = r_ring[RING_W-1 -: WIN*DIGIT_W];
  assign pos        = r_pos;
  assign step_pulse = r_stepPulse;

endmodule

// File: tb/tb_digit_ring_rotator.sv
// Directed self-checking bench for digit_ring_rotator (10 digits, window 4, TICK_DIV 3).
// Manual-step latency expectations follow DIGIT_RING_KEY_SYNC_EN when it is defined.
module tb_digit_ring_rotator;

`ifdef DIGIT_RING_KEY_SYNC_EN
  localparam int KEY_LAT = 2;
`else
  localparam int KEY_LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        key;
  logic        key_enable;
  logic        up;
  logic        rotate;
  logic        load;
  logic [39:0] load_data;
  logic [15:0] d_out;
  logic [3:0]  pos;
  logic        step_pulse;

  int checkCount = 0;
  int passCount  = 0;
  int pulseTotal = 0;
  int pulseBase  = 0;

  digit_ring_rotator #(
    .NUM_DIGITS (10),
    .WIN        (4),
    .DIGIT_W    (4),
    .TICK_DIV   (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key        (key),
    .key_enable (key_enable),
    .up         (up),
    .rotate     (rotate),
    .load       (load),
    .load_data  (load_data),
    .d_out      (d_out),
    .pos        (pos),
    .step_pulse (step_pulse)
  );

  always #5 clk = ~clk;

  // Running count of step pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (step_pulse) pulseTotal++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic stepClock(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    stepClock(2);
    reset = 1'b0;
    stepClock(KEY_LAT + 2);
  endtask

  // One manual press: hold key, release, then let the edge pipeline settle.
  task automatic applyStimulus(input int holdCycles);
    key = 1'b1;
    stepClock(holdCycles);
    key = 1'b0;
    stepClock(KEY_LAT + 2);
  endtask

  initial begin
    reset = 1'b1; key = 1'b0; key_enable = 1'b0; up = 1'b1;
    rotate = 1'b0; load = 1'b0; load_data = '0;

    doReset();
    checkOutput("reset_dout", 64'(d_out), 64'h0123);
    checkOutput("reset_pos", 64'(pos), 64'd0);
    checkOutput("reset_pulse", 64'(step_pulse), 64'd0);

    // Single left step from a key held 5 cycles.
    key_enable = 1'b1; up = 1'b1;
    pulseBase = pulseTotal;
    key = 1'b1;
    stepClock(KEY_LAT);
    checkOutput("key_pulse_early", 64'(step_pulse), 64'd0);
    stepClock(1);
    checkOutput("key_pulse_latency", 64'(step_pulse), 64'd1);
    stepClock(4);
    key = 1'b0;
    stepClock(KEY_LAT + 2);
    checkOutput("left1_dout", 64'(d_out), 64'h1234);
    checkOutput("left1_pos", 64'(pos), 64'd1);
    checkOutput("left1_pulses", 64'(pulseTotal - pulseBase), 64'd1);

    // Two right steps from reset.
    doReset();
    up = 1'b0;
    pulseBase = pulseTotal;
    applyStimulus(1);
    applyStimulus(1);
    checkOutput("right2_dout", 64'(d_out), 64'h8901);
    checkOutput("right2_pos", 64'(pos), 64'd8);
    checkOutput("right2_pulses", 64'(pulseTotal - pulseBase), 64'd2);

    // Right step from position 0 wraps to N-1.
    doReset();
    applyStimulus(1);
    checkOutput("rwrap_dout", 64'(d_out), 64'h9012);
    checkOutput("rwrap_pos", 64'(pos), 64'd9);

    // Ten left steps return to the reset image.
    doReset();
    up = 1'b1;
    pulseBase = pulseTotal;
    for (int i = 0; i < 9; i++) applyStimulus(1);
    checkOutput("left9_dout", 64'(d_out), 64'h9012);
    checkOutput("left9_pos", 64'(pos), 64'd9);
    applyStimulus(2);
    checkOutput("left10_dout", 64'(d_out), 64'h0123);
    checkOutput("left10_pos", 64'(pos), 64'd0);
    checkOutput("left10_pulses", 64'(pulseTotal - pulseBase), 64'd10);

    // Key toggling while disabled must not step.
    key_enable = 1'b0;
    pulseBase = pulseTotal;
    for (int i = 0; i < 4; i++) applyStimulus(1);
    checkOutput("keydis_dout", 64'(d_out), 64'h0123);
    checkOutput("keydis_pos", 64'(pos), 64'd0);
    checkOutput("keydis_pulses", 64'(pulseTotal - pulseBase), 64'd0);

    // Auto-rotate: three steps in nine clocks.
    doReset();
    up = 1'b1;
    pulseBase = pulseTotal;
    rotate = 1'b1;
    stepClock(2);
    checkOutput("rot_pos_before_tick", 64'(pos), 64'd0);
    stepClock(7);
    rotate = 1'b0;
    stepClock(2);
    checkOutput("rot_dout", 64'(d_out), 64'h3456);
    checkOutput("rot_pos", 64'(pos), 64'd3);
    checkOutput("rot_pulses", 64'(pulseTotal - pulseBase), 64'd3);

    // Partial count is abandoned; re-entry needs a full three clocks.
    rotate = 1'b1;
    stepClock(2);
    rotate = 1'b0;
    stepClock(1);
    rotate = 1'b1;
    stepClock(2);
    checkOutput("rot_reentry_wait", 64'(pos), 64'd3);
    stepClock(1);
    checkOutput("rot_reentry_step", 64'(pos), 64'd4);
    rotate = 1'b0;
    stepClock(2);

    // Load coinciding with a key rise wins and suppresses the step.
    doReset();
    key_enable = 1'b1; up = 1'b1;
    applyStimulus(1);
    checkOutput("preload_pos", 64'(pos), 64'd1);
    pulseBase = pulseTotal;
    key = 1'b1;
    stepClock(KEY_LAT);
    load_data = 40'h9876543210;
    load = 1'b1;
    stepClock(1);
    load = 1'b0;
    checkOutput("load_dout", 64'(d_out), 64'h9876);
    checkOutput("load_pos", 64'(pos), 64'd0);
    checkOutput("load_pulse", 64'(step_pulse), 64'd0);
    stepClock(3);
    key = 1'b0;
    checkOutput("load_hold_dout", 64'(d_out), 64'h9876);
    checkOutput("load_pulses", 64'(pulseTotal - pulseBase), 64'd0);
    stepClock(KEY_LAT + 2);

    // Reset overrides a simultaneous load.
    load_data = 40'hFEDCBA9876;
    load = 1'b1;
    reset = 1'b1;
    stepClock(1);
    reset = 1'b0;
    load = 1'b0;
    checkOutput("rstload_dout", 64'(d_out), 64'h0123);
    checkOutput("rstload_pos", 64'(pos), 64'd0);

    // A key held through reset produces no step.
    key = 1'b1;
    reset = 1'b1;
    stepClock(2);
    reset = 1'b0;
    pulseBase = pulseTotal;
    stepClock(KEY_LAT + 4);
    checkOutput("heldkey_pulses", 64'(pulseTotal - pulseBase), 64'd0);
    checkOutput("heldkey_pos", 64'(pos), 64'd0);
    key = 1'b0;
    stepClock(2);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
